// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD frame sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT_NIB,
    ST_INIT_CMD,
    ST_ADDR1,
    ST_DATA1,
    ST_ADDR2,
    ST_DATA2
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] val;
  } lcd_byte_t;

  localparam int unsigned LINE_CHARS = 16;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  // Power-up nibble list, first entry in the top nibble.
  localparam logic [15:0] INIT_NIBS = 16'h3332;

  function automatic logic [3:0] init_nib(input logic [1:0] i);
    return 4'(INIT_NIBS >> (4'(2'd3 - i) * 4'd4));
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_ENTRY;
      2'd2:    return CMD_DISP_ON;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_frame_ctrl_if.sv
// LCD pin bundle plus the frame-completion strobe.
interface lcd_frame_ctrl_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:4] lcd_db;
  logic       frame_done;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_db, frame_done);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_db, frame_done);
endinterface

// File: rtl/lcd_nibble_tx.sv
// Drives one nibble onto the LCD pins with setup and enable-high timing.
module lcd_nibble_tx #(
  parameter int unsigned E_SETUP = 2,
  parameter int unsigned E_HIGH  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);
  localparam int unsigned SLOT = E_SETUP + E_HIGH;
  localparam int unsigned CW   = $clog2(SLOT + 1);

  logic          busy;
  logic [CW-1:0] cnt;

  // cnt is the cycle index within the slot; E is high for indices E_SETUP..SLOT-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        lcd_e  <= 1'b0;
        lcd_rs <= rs;
        lcd_db <= nib;
      end else if (busy) begin
        if (cnt == CW'(SLOT - 1)) begin
          busy  <= 1'b0;
          lcd_e <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt   <= cnt + CW'(1);
          lcd_e <= (32'(cnt) + 32'd1 >= E_SETUP);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_frame_ctrl.sv
// HD44780 4-bit sequencer: power-up init, then endless two-line refresh.
module lcd_frame_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned E_SETUP    = 2,
  parameter int unsigned E_HIGH     = 12,
  parameter int unsigned NIB_GAP    = 50,
  parameter int unsigned BYTE_WAIT  = 2000,
  parameter int unsigned CLEAR_WAIT = 82000,
  parameter int unsigned PWR_WAIT   = 750000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     line1,
  input  logic [127:0]     line2,
  lcd_frame_ctrl_if.master bus
);
  localparam int unsigned WAIT_MAX = (PWR_WAIT > CLEAR_WAIT) ? PWR_WAIT : CLEAR_WAIT;
  localparam int unsigned WW       = $clog2(WAIT_MAX + 1);

  state_t        state, next_state_c, sel_state_c;
  logic [3:0]    idx, next_idx_c, sel_idx_c;
  logic          second, waiting;
  logic [WW-1:0] wcnt, widx_c;
  logic          post_c, in_wait_c, term_c, use_low_c;
  int unsigned   wlen_c;
  lcd_byte_t     tx_byte_c;
  logic [3:0]    nib_c;
  logic [127:0]  shadow1, shadow2;
  logic          done, e_w, rs_w;
  logic [3:0]    db_w;

  function automatic logic [7:0] char_at(input logic [127:0] s, input logic [3:0] i);
    return 8'(s >> (32'(4'd15 - i) * 32'd8));
  endfunction

  function automatic lcd_byte_t sel_byte(input state_t st, input logic [3:0] i,
                                          input logic [127:0] s1, input logic [127:0] s2);
    lcd_byte_t r;
    r = '0;
    case (st)
      ST_INIT_NIB: r.val = {4'h0, init_nib(i[1:0])};
      ST_INIT_CMD: r.val = init_cmd(i[1:0]);
      ST_ADDR1:    r.val = CMD_LINE1;
      ST_ADDR2:    r.val = CMD_LINE2;
      ST_DATA1:    r     = '{rs: 1'b1, val: char_at(s1, i)};
      ST_DATA2:    r     = '{rs: 1'b1, val: char_at(s2, i)};
      default:     r     = '0;
    endcase
    return r;
  endfunction

  // Wait/issue decode: the done cycle counts as wait cycle 0, so no bubble on completion.
  always_comb begin
    post_c    = second || (state == ST_PWR) || (state == ST_INIT_NIB);
    in_wait_c = waiting || done;
    widx_c    = done ? '0 : wcnt;

    wlen_c = BYTE_WAIT;
    if (!post_c)                                      wlen_c = NIB_GAP;
    else if (state == ST_PWR)                         wlen_c = PWR_WAIT;
    else if (state == ST_INIT_NIB && idx != 4'd3)     wlen_c = CLEAR_WAIT;
    else if (state == ST_INIT_CMD && idx == 4'd3)     wlen_c = CLEAR_WAIT;
    term_c = in_wait_c && (widx_c == WW'(wlen_c - 32'd1));

    next_state_c = state;
    next_idx_c   = idx + 4'd1;
    case (state)
      ST_PWR:      begin next_state_c = ST_INIT_NIB; next_idx_c = '0; end
      ST_INIT_NIB: if (idx == 4'd3)  begin next_state_c = ST_INIT_CMD; next_idx_c = '0; end
      ST_INIT_CMD: if (idx == 4'd3)  begin next_state_c = ST_ADDR1;    next_idx_c = '0; end
      ST_ADDR1:    begin next_state_c = ST_DATA1; next_idx_c = '0; end
      ST_DATA1:    if (idx == 4'd15) begin next_state_c = ST_ADDR2;    next_idx_c = '0; end
      ST_ADDR2:    begin next_state_c = ST_DATA2; next_idx_c = '0; end
      ST_DATA2:    if (idx == 4'd15) begin next_state_c = ST_ADDR1;    next_idx_c = '0; end
      default:     begin next_state_c = ST_PWR;   next_idx_c = '0; end
    endcase

    sel_state_c = post_c ? next_state_c : state;
    sel_idx_c   = post_c ? next_idx_c   : idx;
    use_low_c   = !post_c || (next_state_c == ST_INIT_NIB);
    tx_byte_c   = sel_byte(sel_state_c, sel_idx_c, shadow1, shadow2);
    nib_c       = use_low_c ? tx_byte_c.val[3:0] : tx_byte_c.val[7:4];
  end

  // Sequencer state, wait counter and line snapshots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_PWR;
      idx            <= '0;
      second         <= 1'b0;
      waiting        <= 1'b1;
      wcnt           <= '0;
      shadow1        <= '0;
      shadow2        <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (term_c) begin
        waiting <= 1'b0;
        if (post_c) begin
          state  <= next_state_c;
          idx    <= next_idx_c;
          second <= 1'b0;
          if (next_state_c == ST_ADDR1) begin
            shadow1 <= line1;
            shadow2 <= line2;
          end
          bus.frame_done <= (state == ST_DATA2) && (next_state_c == ST_ADDR1);
        end else begin
          second <= 1'b1;
        end
      end else if (in_wait_c) begin
        waiting <= 1'b1;
        wcnt    <= widx_c + WW'(1);
      end
    end
  end

  lcd_nibble_tx #(
    .E_SETUP (E_SETUP),
    .E_HIGH  (E_HIGH)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (term_c),
    .nib    (nib_c),
    .rs     (tx_byte_c.rs),
    .done   (done),
    .lcd_e  (e_w),
    .lcd_rs (rs_w),
    .lcd_db (db_w)
  );

  assign bus.lcd_e  = e_w;
  assign bus.lcd_rs = rs_w;
  assign bus.lcd_db = db_w;
  assign bus.lcd_rw = 1'b0;

endmodule
